// File: rtl/qlearn_step_scheduler.sv
// qlearn_step_scheduler
//
// Sequences the 4-stage Q-learning update pipeline for an 8x8 grid-world.
// Holds the agent state, draws a pseudo-random action from a 16-bit Galois
// LFSR, computes the wall-clamped next state and issues one
// state/action/next-state update per handshake. In-flight updates are
// tracked until stage-4 write-back. Episodes end at GOAL_S or after
// MAX_STEPS steps. After num_episodes episodes the block drains the
// pipeline and reports done.
//
// Optional feature: define QSCHED_HAZARD_EN to enable the read-after-write
// guard. When it is enabled, a request whose state or next state matches an
// update still in flight is held back until that update retires.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   start          one-cycle pulse, honoured only in IDLE or DONE
//   num_episodes   episode count, sampled at start
//   iss_valid/iss_ready, iss_state/iss_action/iss_next
//                  update request to pipeline stage 1
//   wb_valid       one pulse per stage-4 write-back, in issue order
//   busy, done     FSM status (ISSUE/DRAIN, DONE)
//   ep_count       completed episodes
//   step_count     steps taken in the current episode
//   err            sticky: write-back seen with nothing outstanding
module qlearn_step_scheduler #(
  parameter int unsigned         STATE_W    = 6,
  parameter int unsigned         STEP_W     = 8,
  parameter int unsigned         MAX_STEPS  = 255,
  parameter int unsigned         EP_W       = 16,
  parameter int unsigned         PIPE_DEPTH = 4,
  parameter logic [STATE_W-1:0]  START_S    = 6'd0,
  parameter logic [STATE_W-1:0]  GOAL_S     = 6'd63,
  parameter logic [15:0]         LFSR_SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [EP_W-1:0]    num_episodes,
  output logic               iss_valid,
  input  logic               iss_ready,
  output logic [STATE_W-1:0] iss_state,
  output logic [1:0]         iss_action,
  output logic [STATE_W-1:0] iss_next,
  input  logic               wb_valid,
  output logic               busy,
  output logic               done,
  output logic [EP_W-1:0]    ep_count,
  output logic [STEP_W-1:0]  step_count,
  output logic               err
);

  localparam int unsigned CNT_W = $clog2(PIPE_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [STATE_W-1:0]   s_q, s_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [EP_W-1:0]      ep_q, ep_d;
  logic [EP_W-1:0]      neps_q, neps_d;
  logic [CNT_W-1:0]     out_q, out_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [STATE_W-1:0]   next_s;
  logic                 hazard;
  logic                 fire;
  logic                 pop;

  // Grid coordinates of the current state.
  logic [2:0] row, col;
  assign row = s_q[5:3];
  assign col = s_q[2:0];

  // Wall-clamped move: a move off the grid leaves the agent in place.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    next_s = s_q;
    unique case (lfsr_q[1:0])
      2'b00: if (col != 3'd0) next_s = {row, col - 3'd1};  // left
      2'b01: if (row != 3'd0) next_s = {row - 3'd1, col};  // up
      2'b10: if (col != 3'd7) next_s = {row, col + 3'd1};  // right
      2'b11: if (row != 3'd7) next_s = {row + 3'd1, col};  // down
    endcase
  end

`ifdef QSCHED_HAZARD_EN
  // Scoreboard of states issued but not yet written back, oldest in slot 0.
  logic [STATE_W-1:0] sb_q [PIPE_DEPTH];
  logic [STATE_W-1:0] sb_d [PIPE_DEPTH];
  logic [CNT_W-1:0]   wr_idx;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if ((CNT_W'(i) < out_q) && ((sb_q[i] == s_q) || (sb_q[i] == next_s))) begin
        hazard = 1'b1;
      end
    end
  end

  // A simultaneous pop shifts everything down one slot before the push lands.
  always_comb begin
    sb_d   = sb_q;
    wr_idx = pop ? (out_q - CNT_W'(1)) : out_q;
    if (pop) begin
      for (int i = 0; i < PIPE_DEPTH - 1; i++) sb_d[i] = sb_q[i + 1];
    end
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (fire && (CNT_W'(i) == wr_idx)) sb_d[i] = s_q;
    end
  end

  // NOTE: the scoreboard storage is deliberately not reset; slots at or
  // above out_q are never compared, so their contents are don't-care.
  always_ff @(posedge clk) begin
    sb_q <= sb_d;
  end
`else
  assign hazard = 1'b0;
`endif

  assign iss_valid = (state_q == ISSUE) && (out_q < CNT_W'(PIPE_DEPTH)) && !hazard;
  assign fire      = iss_valid && iss_ready;
  assign pop       = wb_valid && (out_q != '0);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    lfsr_d  = lfsr_q;
    step_d  = step_q;
    ep_d    = ep_q;
    neps_d  = neps_q;
    out_d   = out_q;
    err_d   = err_q | (wb_valid && (out_q == '0));

    unique case ({fire, pop})
      2'b10:   out_d = out_q + CNT_W'(1);
      2'b01:   out_d = out_q - CNT_W'(1);
      default: out_d = out_q;
    endcase

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          neps_d  = num_episodes;
          s_d     = START_S;
          step_d  = '0;
          ep_d    = '0;
          state_d = (num_episodes == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (fire) begin
          // Right-shift Galois form of x^16+x^14+x^13+x^11+1.
          lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
          if ((next_s == GOAL_S) || (step_q == STEP_W'(MAX_STEPS - 1))) begin
            ep_d   = ep_q + EP_W'(1);
            step_d = '0;
            s_d    = START_S;
            if ((ep_q + EP_W'(1)) == neps_q) state_d = DRAIN;
          end else begin
            s_d    = next_s;
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      DRAIN: begin
        if (out_q == '0) state_d = DONE;
      end
    endcase

    busy_d = (state_d == ISSUE) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      s_q     <= START_S;
      lfsr_q  <= LFSR_SEED;
      step_q  <= '0;
      ep_q    <= '0;
      neps_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      lfsr_q  <= lfsr_d;
      step_q  <= step_d;
      ep_q    <= ep_d;
      neps_q  <= neps_d;
      out_q   <= out_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign iss_state  = s_q;
  assign iss_action = lfsr_q[1:0];
  assign iss_next   = next_s;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ep_count   = ep_q;
  assign step_count = step_q;
  assign err        = err_q;

endmodule

// File: tb/tb_qlearn_step_scheduler.sv
// Self-checking bench for qlearn_step_scheduler. Two instances run side by
// side: dut_a with default parameters and dut_b with MAX_STEPS=3. A
// transaction-level reference model (grid coordinates, queues for in-flight
// updates) predicts every output each cycle; a bench-side pipeline queue
// echoes write-backs after a configurable latency.
module tb_qlearn_step_scheduler;

  localparam int          NDUT  = 2;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          START = 0;
  localparam int          GOAL  = 63;
  localparam int          DEPTH = 4;
`ifdef QSCHED_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic clk;
  logic rst;

  logic        start_s [NDUT];
  logic [15:0] num_s   [NDUT];
  logic        rdy_s   [NDUT];
  logic        wb_s    [NDUT];
  logic        iv_o    [NDUT];
  logic [5:0]  ist_o   [NDUT];
  logic [5:0]  inx_o   [NDUT];
  logic [1:0]  iac_o   [NDUT];
  logic        busy_o  [NDUT];
  logic        done_o  [NDUT];
  logic        err_o   [NDUT];
  logic [15:0] ep_o    [NDUT];
  logic [7:0]  stp_o   [NDUT];

  qlearn_step_scheduler dut_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .num_episodes(num_s[0]),
    .iss_valid(iv_o[0]), .iss_ready(rdy_s[0]), .iss_state(ist_o[0]),
    .iss_action(iac_o[0]), .iss_next(inx_o[0]), .wb_valid(wb_s[0]),
    .busy(busy_o[0]), .done(done_o[0]), .ep_count(ep_o[0]),
    .step_count(stp_o[0]), .err(err_o[0])
  );

  qlearn_step_scheduler #(.MAX_STEPS(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .num_episodes(num_s[1]),
    .iss_valid(iv_o[1]), .iss_ready(rdy_s[1]), .iss_state(ist_o[1]),
    .iss_action(iac_o[1]), .iss_next(inx_o[1]), .wb_valid(wb_s[1]),
    .busy(busy_o[1]), .done(done_o[1]), .ep_count(ep_o[1]),
    .step_count(stp_o[1]), .err(err_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 issuing, 2 draining, 3 done.
  int          m_phase  [NDUT];
  int          m_s      [NDUT];
  logic [15:0] m_lfsr   [NDUT];
  int          m_steps  [NDUT];
  int          m_eps    [NDUT];
  int          m_target [NDUT];
  bit          m_err    [NDUT];
  int          m_sb     [NDUT][$];
  int          pipe     [NDUT][$];

  int          tests, fails, cyc, fires_b;
  int          ready_pct, lat_min, lat_max;
  bit          wb_hold;
  bit          force_wb   [NDUT];
  bit          pend_start [NDUT];
  logic [15:0] pend_num   [NDUT];
  bit          stall_chk;
  int          exp_s, exp_a, exp_n;

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: observed %0h expected %0h (cycle %0d)", tag, k, obs, exp, cyc);
    end
  endtask

  function automatic int max_steps(input int k);
    return (k == 0) ? 255 : 3;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int m_next(input int k);
    int row, col;
    row = m_s[k] / 8;
    col = m_s[k] % 8;
    case (m_lfsr[k] % 4)
      0:       return (col > 0) ? m_s[k] - 1 : m_s[k];
      1:       return (row > 0) ? m_s[k] - 8 : m_s[k];
      2:       return (col < 7) ? m_s[k] + 1 : m_s[k];
      default: return (row < 7) ? m_s[k] + 8 : m_s[k];
    endcase
  endfunction

  function automatic bit m_hazard(input int k);
    int nx;
    if (!HAZ) return 1'b0;
    nx = m_next(k);
    for (int i = 0; i < m_sb[k].size(); i++)
      if (m_sb[k][i] == m_s[k] || m_sb[k][i] == nx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_valid(input int k);
    return (m_phase[k] == 1) && (m_sb[k].size() < DEPTH) && !m_hazard(k);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_phase[k] = 0; m_s[k] = START; m_lfsr[k] = SEED; m_steps[k] = 0;
      m_eps[k] = 0; m_target[k] = 0; m_err[k] = 1'b0;
      m_sb[k].delete(); pipe[k].delete();
    end
    fires_b = 0;
  endtask

  task automatic check_outputs(input int k);
    check("iss_valid",  k, iv_o[k],   m_valid(k));
    check("iss_state",  k, ist_o[k],  m_s[k]);
    check("iss_action", k, iac_o[k],  m_lfsr[k] % 4);
    check("iss_next",   k, inx_o[k],  m_next(k));
    check("busy",       k, busy_o[k], (m_phase[k] == 1 || m_phase[k] == 2));
    check("done",       k, done_o[k], (m_phase[k] == 3));
    check("ep_count",   k, ep_o[k],   m_eps[k]);
    check("step_count", k, stp_o[k],  m_steps[k]);
    check("err",        k, err_o[k],  m_err[k]);
  endtask

  task automatic model_update(input int k, input bit st, input logic [15:0] num,
                              input bit rdy, input bit wb);
    int old_n, nx;
    bit fire;
    old_n = m_sb[k].size();
    nx    = m_next(k);
    fire  = m_valid(k) && rdy;
    if (wb) begin
      if (old_n > 0) void'(m_sb[k].pop_front());
      else m_err[k] = 1'b1;
    end
    case (m_phase[k])
      0, 3: if (st) begin
        m_target[k] = num; m_s[k] = START; m_steps[k] = 0; m_eps[k] = 0;
        m_phase[k]  = (num == 0) ? 2 : 1;
        if (k == 1) fires_b = 0;
      end
      1: if (fire) begin
        if (k == 1) begin
          // With the goal out of reach every third fire restarts the episode.
          check("b_step_mod3", k, stp_o[1], fires_b % 3);
          if (fires_b % 3 == 0) check("b_restart_state", k, ist_o[1], START);
          fires_b++;
        end
        m_lfsr[k] = lfsr_next(m_lfsr[k]);
        m_sb[k].push_back(m_s[k]);
        pipe[k].push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        if (nx == GOAL || m_steps[k] == max_steps(k) - 1) begin
          m_eps[k]++; m_steps[k] = 0; m_s[k] = START;
          if (m_eps[k] == m_target[k]) m_phase[k] = 2;
        end else begin
          m_s[k] = nx; m_steps[k]++;
        end
      end
      2: if (old_n == 0) m_phase[k] = 3;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      bit w;
      start_s[k] = pend_start[k];
      num_s[k]   = pend_num[k];
      rdy_s[k]   = ($urandom_range(99) < ready_pct);
      w = force_wb[k];
      if (!w && !wb_hold && pipe[k].size() > 0 && pipe[k][0] <= cyc) begin
        w = 1'b1;
        void'(pipe[k].pop_front());
      end
      wb_s[k] = w;
    end
    #1;
    for (int k = 0; k < NDUT; k++) check_outputs(k);
    if (stall_chk) begin
      check("stall_state",  0, ist_o[0], exp_s);
      check("stall_action", 0, iac_o[0], exp_a);
      check("stall_next",   0, inx_o[0], exp_n);
    end
    for (int k = 0; k < NDUT; k++) model_update(k, pend_start[k], pend_num[k], rdy_s[k], wb_s[k]);
    for (int k = 0; k < NDUT; k++) begin
      pend_start[k] = 1'b0;
      force_wb[k]   = 1'b0;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (((m_phase[0] == 1) || (m_phase[0] == 2) || (m_phase[1] == 1) || (m_phase[1] == 2))
           && n < budget) begin
      tick();
      n++;
    end
    check("finish_in_budget", 0, (n < budget), 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      start_s[k] = 1'b0; rdy_s[k] = 1'b0; wb_s[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic start_dut(input int k, input int num);
    pend_start[k] = 1'b1;
    pend_num[k]   = 16'(num);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; stall_chk = 1'b0;
    ready_pct = 100; wb_hold = 1'b0; lat_min = 4; lat_max = 4;
    exp_s = 0; exp_a = 0; exp_n = 0;
    rst = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      pend_start[k] = 1'b0; pend_num[k] = '0; force_wb[k] = 1'b0;
      start_s[k] = 1'b0; num_s[k] = '0; rdy_s[k] = 1'b0; wb_s[k] = 1'b0;
    end

    // Reset state, then idle cycles.
    do_reset();
    repeat (3) tick();

    // One episode on dut_a (ends at goal or step limit), two on dut_b,
    // ready always high, write-back echoed four cycles after each fire.
    start_dut(0, 1);
    start_dut(1, 2);
    tick();
    run_until_idle(5000);

    // Random ready and latency; a start while busy must be ignored.
    ready_pct = 60; lat_min = 1; lat_max = 6;
    start_dut(0, 3);
    start_dut(1, 5);
    tick();
    repeat (10) tick();
    start_dut(0, 7);
    tick();
    run_until_idle(8000);

    // Ready withheld for five cycles: payload must hold.
    ready_pct = 100; lat_min = 4; lat_max = 4;
    start_dut(0, 1);
    tick();
    repeat (3) tick();
    exp_s = m_s[0]; exp_a = m_lfsr[0] % 4; exp_n = m_next(0);
    ready_pct = 0; stall_chk = 1'b1;
    repeat (5) tick();
    stall_chk = 1'b0; ready_pct = 100;
    run_until_idle(5000);

    // Write-back withheld: issue stalls on full or hazard, then resumes.
    lat_min = 2; lat_max = 5;
    start_dut(0, 2);
    start_dut(1, 4);
    tick();
    wb_hold = 1'b1;
    repeat (12) tick();
    wb_hold = 1'b0;
    run_until_idle(5000);

    // Reset in the middle of an episode flushes block and bench pipeline.
    ready_pct = 70;
    start_dut(0, 3);
    start_dut(1, 3);
    tick();
    repeat (30) tick();
    do_reset();
    repeat (3) tick();

    // Stray write-back sets err; it survives a start and clears on reset.
    ready_pct = 100;
    force_wb[0] = 1'b1;
    tick();
    repeat (2) tick();
    start_dut(0, 0);
    tick();
    repeat (3) tick();
    do_reset();
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
